// File: rtl/snr_meas_ctrl_if.sv
// rtl/snr_meas_ctrl_if.sv - control, sample and result bundle for snr_meas_ctrl
//
// Purpose: groups every non-clock, non-reset signal of the SNR measurement
// controller so the controller and its driver share one connection point.
//
// Signals (direction given from the controller's side, modport slave):
//   start        in   1   one-cycle request to begin a measurement
//   abort        in   1   synchronous cancel of the measurement in progress
//   continuous   in   1   restart a window automatically after each result
//   win_log2     in   4   window length exponent (clamped to 4..10)
//   sample_valid in   1   qualifies filtered / un_filtered
//   filtered     in  10   unsigned filtered sample magnitude
//   un_filtered  in  10   unsigned unfiltered sample magnitude
//   thr          in  17   low-SNR threshold
//   busy         out  1   high whenever the controller is not idle
//   snr          out 17   last SNR result, held between results
//   snr_valid    out  1   one-cycle strobe marking a new snr
//   div_zero     out  1   last result saturated because unf_sum <= filt_sum
//   snr_low      out  1   last snr was below thr

interface snr_meas_ctrl_if;
    logic        start;
    logic        abort;
    logic        continuous;
    logic [3:0]  win_log2;
    logic        sample_valid;
    logic [9:0]  filtered;
    logic [9:0]  un_filtered;
    logic [16:0] thr;
    logic        busy;
    logic [16:0] snr;
    logic        snr_valid;
    logic        div_zero;
    logic        snr_low;

    modport master (
        output start, abort, continuous, win_log2, sample_valid,
               filtered, un_filtered, thr,
        input  busy, snr, snr_valid, div_zero, snr_low
    );

    modport slave (
        input  start, abort, continuous, win_log2, sample_valid,
               filtered, un_filtered, thr,
        output busy, snr, snr_valid, div_zero, snr_low
    );
endinterface

// File: rtl/snr_meas_ctrl.sv
// rtl/snr_meas_ctrl.sv - windowed SNR measurement controller with serial divider
//
// Purpose: accumulates 2^win filtered and unfiltered sample magnitudes, then
// divides filt_sum by (unf_sum - filt_sum) with a 20-cycle restoring divider
// and publishes the saturated 17-bit quotient as the SNR result.
//
// Ports:
//   clk   in  clock, all state updates on the rising edge
//   rstn  in  asynchronous active-low reset
//   bus   snr_meas_ctrl_if.slave (start/abort/continuous/win_log2, sample
//         stream, thr; busy/snr/snr_valid/div_zero/snr_low)
//
// Build option: define SNR_MEAS_CTRL_AVG_EN to make snr an exponential
// average (weight 1/4) of successive results instead of the latest result.

module snr_meas_ctrl (
    input  logic            clk,
    input  logic            rstn,
    snr_meas_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DIV   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [16:0] SNR_MAX = 17'h1FFFF;

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  win;
    logic [10:0] cnt;
    logic [19:0] filt_sum;
    logic [19:0] unf_sum;
    logic [19:0] quo;
    logic [19:0] rem;
    logic [4:0]  div_cnt;
    logic [16:0] snr_r;
    logic        div_zero_r;
    logic        snr_low_r;
`ifdef SNR_MEAS_CTRL_AVG_EN
    logic        avg_valid;
`endif

    logic [3:0]  win_clamped;
    logic [10:0] win_len;
    logic        accept;
    logic        last_sample;
    logic        div_last;
    logic        start_window;
    logic [19:0] divisor;
    logic [20:0] rem_sh;
    logic        sub_ok;
    logic [19:0] rem_nxt;
    logic [19:0] quo_nxt;
    logic        dz_now;
    logic [16:0] q_sat;
    logic [16:0] snr_new;

    always_comb begin
        if (bus.win_log2 < 4'd4) begin
            win_clamped = 4'd4;
        end else if (bus.win_log2 > 4'd10) begin
            win_clamped = 4'd10;
        end else begin
            win_clamped = bus.win_log2;
        end
    end

    assign win_len      = 11'd1 << win;
    assign accept       = (state == ACCUM) && bus.sample_valid && !bus.abort;
    assign last_sample  = accept && (cnt == win_len - 11'd1);
    assign div_last     = (state == DIV) && (div_cnt == 5'd19);
    assign start_window = !bus.abort &&
                          (((state == IDLE) && bus.start) ||
                           ((state == DONE) && bus.continuous));

    // Restoring divider: the dividend is shifted out of quo from the top while
    // quotient bits are shifted in at the bottom. The remainder is always
    // below the divisor, so the 20-bit subtraction cannot lose information.
    assign divisor = unf_sum - filt_sum;
    assign rem_sh  = {rem, quo[19]};
    assign sub_ok  = rem_sh >= {1'b0, divisor};
    assign rem_nxt = sub_ok ? (rem_sh[19:0] - divisor) : rem_sh[19:0];
    assign quo_nxt = {quo[18:0], sub_ok};

    assign dz_now = unf_sum <= filt_sum;
    assign q_sat  = (quo_nxt[19:17] != 3'd0) ? SNR_MAX : quo_nxt[16:0];

    always_comb begin
        snr_new = q_sat;
        if (dz_now) begin
            snr_new = SNR_MAX;
        end
`ifdef SNR_MEAS_CTRL_AVG_EN
        else if (avg_valid) begin
            snr_new = 17'($signed({1'b0, snr_r}) +
                          (($signed({1'b0, q_sat}) - $signed({1'b0, snr_r})) >>> 2));
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_nxt = ACCUM;
                ACCUM:   if (last_sample) state_nxt = DIV;
                DIV:     if (div_last) state_nxt = DONE;
                DONE:    state_nxt = bus.continuous ? ACCUM : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win        <= 4'd4;
            cnt        <= '0;
            filt_sum   <= '0;
            unf_sum    <= '0;
            quo        <= '0;
            rem        <= '0;
            div_cnt    <= '0;
            snr_r      <= '0;
            div_zero_r <= 1'b0;
            snr_low_r  <= 1'b0;
`ifdef SNR_MEAS_CTRL_AVG_EN
            avg_valid  <= 1'b0;
`endif
        end else if (bus.abort) begin
`ifdef SNR_MEAS_CTRL_AVG_EN
            // The next result after an abort starts a fresh average.
            avg_valid  <= 1'b0;
`endif
        end else begin
            if (start_window) begin
                win      <= win_clamped;
                cnt      <= '0;
                filt_sum <= '0;
                unf_sum  <= '0;
            end
            if (accept) begin
                filt_sum <= filt_sum + {10'd0, bus.filtered};
                unf_sum  <= unf_sum + {10'd0, bus.un_filtered};
                cnt      <= cnt + 11'd1;
                if (last_sample) begin
                    // Seed the divider with the final sum, including this sample.
                    quo     <= filt_sum + {10'd0, bus.filtered};
                    rem     <= '0;
                    div_cnt <= '0;
                end
            end
            if (state == DIV) begin
                quo     <= quo_nxt;
                rem     <= rem_nxt;
                div_cnt <= div_cnt + 5'd1;
                if (div_last) begin
                    snr_r      <= snr_new;
                    div_zero_r <= dz_now;
                    snr_low_r  <= snr_new < bus.thr;
`ifdef SNR_MEAS_CTRL_AVG_EN
                    avg_valid  <= 1'b1;
`endif
                end
            end
        end
    end

    assign bus.busy      = state != IDLE;
    assign bus.snr_valid = state == DONE;
    assign bus.snr       = snr_r;
    assign bus.div_zero  = div_zero_r;
    assign bus.snr_low   = snr_low_r;

endmodule

// File: tb/tb_snr_meas_ctrl.sv
// tb/tb_snr_meas_ctrl.sv - self-checking bench for snr_meas_ctrl

module tb_snr_meas_ctrl;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    snr_meas_ctrl_if bus ();

    snr_meas_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int last_cyc = 0;

    typedef struct {
        logic [3:0]  wl;
        int          n;
        logic [9:0]  f;
        logic [9:0]  u;
        logic [9:0]  lu;
        logic [16:0] thr;
        logic [16:0] es;
        logic        edz;
        logic        elow;
    } vec_t;

    vec_t tab[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
    endtask

    // Presents n accepted samples (the last one with un_filtered = lu),
    // optionally on alternate cycles and with stray start pulses.
    task automatic feed(input string name, input int n, input logic [9:0] f,
                        input logic [9:0] u, input logic [9:0] lu,
                        input bit toggle, input bit noise, input bit exp_busy);
        int k = 0;
        int i = 0;
        int early = 0;
        while (k < n && i < 5000) begin
            @(negedge clk);
            if (bus.snr_valid) early++;
            bus.start = noise && (i % 5 == 2);
            if (!toggle || (i % 2 == 0)) begin
                bus.sample_valid = 1'b1;
                bus.filtered     = f;
                bus.un_filtered  = (k == n - 1) ? lu : u;
                k++;
            end else begin
                bus.sample_valid = 1'b0;
            end
            i++;
        end
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.start        = 1'b0;
        last_cyc         = cyc;
        check({name, " early_valid"}, early, 0);
        check({name, " busy_after_feed"}, bus.busy, exp_busy);
    endtask

    task automatic wait_result(input string name, input logic [16:0] es,
                               input bit edz, input bit elow, input bit exp_busy);
        int t = 0;
        while (!bus.snr_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({name, " latency"}, cyc - last_cyc, 20);
        check({name, " snr"}, bus.snr, es);
        check({name, " div_zero"}, bus.div_zero, edz);
        check({name, " snr_low"}, bus.snr_low, elow);
        @(negedge clk);
        check({name, " valid_width"}, bus.snr_valid, 1'b0);
        check({name, " busy_after"}, bus.busy, exp_busy);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.continuous   = 1'b0;
        bus.win_log2     = 4'd4;
        bus.sample_valid = 1'b0;
        bus.filtered     = '0;
        bus.un_filtered  = '0;
        bus.thr          = '0;

        tab[0] = '{4'd4,  16, 10'd100,  10'd110,  10'd110,  17'd20,      17'd10,      1'b0, 1'b1};
        tab[1] = '{4'd4,  16, 10'd50,   10'd50,   10'd50,   17'd5,       17'h1FFFF,   1'b1, 1'b0};
        tab[2] = '{4'd4,  16, 10'd110,  10'd100,  10'd100,  17'h1FFFF,   17'h1FFFF,   1'b1, 1'b0};
        tab[3] = '{4'd2,  16, 10'd30,   10'd40,   10'd40,   17'd2,       17'd3,       1'b0, 1'b0};
        tab[4] = '{4'd4,  16, 10'd1000, 10'd1001, 10'd1001, 17'h1FFFF,   17'd1000,    1'b0, 1'b1};
        tab[5] = '{4'd8,  256, 10'd1000, 10'd1000, 10'd1001, 17'h1FFFF,  17'h1FFFF,   1'b0, 1'b0};
        tab[6] = '{4'd5,  32, 10'd7,    10'd9,    10'd9,    17'd3,       17'd3,       1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("reset busy", bus.busy, 1'b0);
        check("reset snr", bus.snr, 17'd0);
        check("reset snr_valid", bus.snr_valid, 1'b0);
        check("reset div_zero", bus.div_zero, 1'b0);
        check("reset snr_low", bus.snr_low, 1'b0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle without start", bus.busy, 1'b0);

        for (int r = 0; r < 7; r++) begin
            pulse_abort();
            bus.win_log2 = tab[r].wl;
            bus.thr      = tab[r].thr;
            pulse_start();
            feed($sformatf("row%0d", r), tab[r].n, tab[r].f, tab[r].u, tab[r].lu, 1'b0, 1'b0, 1'b1);
            wait_result($sformatf("row%0d", r), tab[r].es, tab[r].edz, tab[r].elow, 1'b0);
        end

        // Oversized exponent clamps to a 1024-sample window; sparse samples and
        // start pulses while busy must not disturb it.
        pulse_abort();
        bus.win_log2 = 4'd15;
        bus.thr      = 17'd1;
        pulse_start();
        feed("win15", 1024, 10'd3, 10'd4, 10'd4, 1'b1, 1'b1, 1'b1);
        wait_result("win15", 17'd3, 1'b0, 1'b0, 1'b0);

        // Abort on the 10th divide cycle: result must not appear.
        bus.win_log2 = 4'd4;
        bus.thr      = 17'd20;
        pulse_start();
        feed("abort", 16, 10'd100, 10'd110, 10'd110, 1'b0, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort busy", bus.busy, 1'b0);
        check("abort snr_valid", bus.snr_valid, 1'b0);
        check("abort snr kept", bus.snr, 17'd3);
        begin
            int seen = 0;
            repeat (30) begin
                @(negedge clk);
                if (bus.snr_valid) seen++;
            end
            check("abort no late valid", seen, 0);
        end
        check("abort div_zero kept", bus.div_zero, 1'b0);
        check("abort snr_low kept", bus.snr_low, 1'b0);

        // Continuous mode: back-to-back windows, then drop continuous.
        pulse_abort();
        bus.win_log2   = 4'd4;
        bus.thr        = 17'd20;
        bus.continuous = 1'b1;
        pulse_start();
        feed("cont1", 16, 10'd100, 10'd110, 10'd110, 1'b0, 1'b0, 1'b1);
        wait_result("cont1", 17'd10, 1'b0, 1'b1, 1'b1);
        feed("cont2", 16, 10'd60, 10'd80, 10'd80, 1'b0, 1'b0, 1'b1);
        bus.continuous = 1'b0;
`ifdef SNR_MEAS_CTRL_AVG_EN
        wait_result("cont2", 17'd8, 1'b0, 1'b1, 1'b0);
`else
        wait_result("cont2", 17'd3, 1'b0, 1'b1, 1'b0);
`endif

        // Asynchronous reset mid-window clears outputs at once.
        pulse_start();
        repeat (5) begin
            @(negedge clk);
            bus.sample_valid = 1'b1;
            bus.filtered     = 10'd100;
            bus.un_filtered  = 10'd110;
        end
        @(negedge clk);
        bus.sample_valid = 1'b0;
        #1;
        rstn = 1'b0;
        #1;
        check("async busy", bus.busy, 1'b0);
        check("async snr", bus.snr, 17'd0);
        check("async snr_valid", bus.snr_valid, 1'b0);
        check("async div_zero", bus.div_zero, 1'b0);
        check("async snr_low", bus.snr_low, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        feed("no_start", 16, 10'd100, 10'd110, 10'd110, 1'b0, 1'b0, 1'b0);
        begin
            int seen = 0;
            repeat (25) begin
                @(negedge clk);
                if (bus.snr_valid || bus.busy) seen++;
            end
            check("no_start idle", seen, 0);
        end

        // Two results after reset: 10 then 30.
        pulse_start();
        feed("avg1", 16, 10'd100, 10'd110, 10'd110, 1'b0, 1'b0, 1'b1);
        wait_result("avg1", 17'd10, 1'b0, 1'b1, 1'b0);
        pulse_start();
        feed("avg2", 16, 10'd300, 10'd310, 10'd310, 1'b0, 1'b0, 1'b1);
`ifdef SNR_MEAS_CTRL_AVG_EN
        wait_result("avg2", 17'd15, 1'b0, 1'b1, 1'b0);
`else
        wait_result("avg2", 17'd30, 1'b0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
